// File: rtl/rpn_pkg.sv
// Shared constants and types for the RPN evaluator: ASCII codes, error codes, FSM states.
package rpn_pkg;

    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;
    localparam logic [7:0] CH_ADD = 8'h2B;
    localparam logic [7:0] CH_SUB = 8'h2D;
    localparam logic [7:0] CH_MUL = 8'h2A;
    localparam logic [7:0] CH_DIV = 8'h2F;
    localparam logic [7:0] CH_EQ  = 8'h3D;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_UNDER = 3'd1;
    localparam logic [2:0] ERR_OVER  = 3'd2;
    localparam logic [2:0] ERR_DIVZ  = 3'd3;
    localparam logic [2:0] ERR_CHAR  = 3'd4;
    localparam logic [2:0] ERR_TERM  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DIV,
        ST_OUT
    } state_e;

endpackage

// File: rtl/rpn_eval_if.sv
// Character-in / result-out handshake bundle between the RPN source, the evaluator and its consumer.
interface rpn_eval_if #(
    parameter int WIDTH = 16
);
    logic             in_stb;
    logic [7:0]       in_char;
    logic             in_ack;
    logic             out_stb;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_err;
    logic             out_ack;

    modport master (
        output in_stb, in_char, out_ack,
        input  in_ack, out_stb, out_result, out_err
    );

    modport slave (
        input  in_stb, in_char, out_ack,
        output in_ack, out_stb, out_result, out_err
    );
endinterface

// File: rtl/rpn_div.sv
// Restoring divider on unsigned magnitudes; one quotient bit per cycle, WIDTH cycles after start.
module rpn_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o
);
    localparam int CNTW = $clog2(WIDTH + 1);

    logic             busy_q, busy_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
    logic [WIDTH:0]   rem_sh, diff;
    logic             qbit;
    logic [WIDTH-1:0] dvd_nxt, rem_nxt;

    // Dividend register doubles as the quotient shift register.
    assign rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, dvs_q};
    assign qbit    = ~diff[WIDTH];
    assign rem_nxt = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign dvd_nxt = {dvd_q[WIDTH-2:0], qbit};

    // Quotient is presented combinationally in the final iteration so the caller can push it that cycle.
    assign done_o = busy_q && (cnt_q == CNTW'(1));
    assign quot_o = dvd_nxt;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        rem_d  = rem_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CNTW'(WIDTH);
            dvd_d  = dvd_i;
            dvs_d  = dvs_i;
            rem_d  = '0;
        end else if (busy_q) begin
            dvd_d = dvd_nxt;
            rem_d = rem_nxt;
            cnt_d = cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
        end
    end
endmodule

// File: rtl/rpn_eval.sv
// Evaluates an ASCII RPN stream on an operand stack and returns one result plus error code per expression.
module rpn_eval
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input logic       clk_i,
    input logic       rst_ni,
    rpn_eval_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] stk_q [DEPTH];
    logic [WIDTH-1:0] stk_d [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       err_q, err_d;
    logic [7:0]       char_q, char_d;
    logic             neg_q, neg_d;
    logic             in_ack_q, in_ack_d;
    logic             out_stb_q, out_stb_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [2:0]       out_err_q, out_err_d;

    logic [AW-1:0]    a_ix, b_ix;
    logic [WIDTH-1:0] opa, opb, alu, a_mag, b_mag, div_quot;
    logic             is_digit, is_op, div_start, div_done;

    assign b_ix     = AW'(cnt_q - CW'(1));
    assign a_ix     = AW'(cnt_q - CW'(2));
    assign opb      = stk_q[b_ix];
    assign opa      = stk_q[a_ix];
    assign a_mag    = opa[WIDTH-1] ? -opa : opa;
    assign b_mag    = opb[WIDTH-1] ? -opb : opb;
    assign is_digit = (char_q >= CH_0) && (char_q <= CH_9);
    assign is_op    = (char_q == CH_ADD) || (char_q == CH_SUB) ||
                      (char_q == CH_MUL) || (char_q == CH_DIV);

    always_comb begin
        unique case (char_q)
            CH_ADD:  alu = opa + opb;
            CH_SUB:  alu = opa - opb;
            CH_MUL:  alu = opa * opb;
            default: alu = '0;
        endcase
    end

    rpn_div #(.WIDTH(WIDTH)) u_div (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (div_start),
        .dvd_i   (a_mag),
        .dvs_i   (b_mag),
        .done_o  (div_done),
        .quot_o  (div_quot)
    );

    always_comb begin
        state_d      = state_q;
        stk_d        = stk_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        char_d       = char_q;
        neg_d        = neg_q;
        in_ack_d     = 1'b0;
        out_stb_d    = out_stb_q;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;
        div_start    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A char still on the bus during its own ack cycle must not be taken twice.
                if (bus.in_stb && !in_ack_q) begin
                    in_ack_d = 1'b1;
                    char_d   = bus.in_char;
                    if (bus.in_char == CH_EQ) begin
                        state_d   = ST_OUT;
                        out_stb_d = 1'b1;
                        if (err_q != ERR_NONE) begin
                            out_err_d    = err_q;
                            out_result_d = '0;
                        end else if (cnt_q != CW'(1)) begin
                            out_err_d    = ERR_TERM;
                            out_result_d = '0;
                        end else begin
                            out_err_d    = ERR_NONE;
                            out_result_d = stk_q[0];
                        end
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                if (err_q == ERR_NONE) begin
                    if (is_digit) begin
                        if (cnt_q == CW'(DEPTH)) err_d = ERR_OVER;
                        else begin
                            stk_d[cnt_q[AW-1:0]] = {{(WIDTH-4){1'b0}}, char_q[3:0]};
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (is_op) begin
                        if (cnt_q < CW'(2)) err_d = ERR_UNDER;
                        else if (char_q == CH_DIV) begin
                            if (opb == '0) err_d = ERR_DIVZ;
                            else begin
                                div_start = 1'b1;
                                neg_d     = opa[WIDTH-1] ^ opb[WIDTH-1];
                                state_d   = ST_DIV;
                            end
                        end else begin
                            stk_d[a_ix] = alu;
                            cnt_d       = cnt_q - CW'(1);
                        end
                    end else begin
                        err_d = ERR_CHAR;
                    end
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    stk_d[a_ix] = neg_q ? -div_quot : div_quot;
                    cnt_d       = cnt_q - CW'(1);
                    state_d     = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (bus.out_ack) begin
                    state_d      = ST_IDLE;
                    out_stb_d    = 1'b0;
                    out_result_d = '0;
                    out_err_d    = ERR_NONE;
                    cnt_d        = '0;
                    err_d        = ERR_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
            cnt_q        <= '0;
            err_q        <= ERR_NONE;
            char_q       <= '0;
            neg_q        <= 1'b0;
            in_ack_q     <= 1'b0;
            out_stb_q    <= 1'b0;
            out_result_q <= '0;
            out_err_q    <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            stk_q        <= stk_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            char_q       <= char_d;
            neg_q        <= neg_d;
            in_ack_q     <= in_ack_d;
            out_stb_q    <= out_stb_d;
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
        end
    end

    assign bus.in_ack     = in_ack_q;
    assign bus.out_stb    = out_stb_q;
    assign bus.out_result = out_result_q;
    assign bus.out_err    = out_err_q;
endmodule

// File: tb/tb_rpn_eval.sv
// Directed bench for rpn_eval: arithmetic, division timing, error codes, output hold and async reset.
module tb_rpn_eval;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_pass;
    int   last_ack;
    int   prev_ack;
    int   div_ack;

    rpn_eval_if #(.WIDTH(WIDTH)) bus ();

    rpn_eval #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present one char, wait (bounded) for its ack, then drop strobe and confirm the ack was a single pulse.
    task automatic send(input byte c);
        int n;
        bus.in_char = c;
        bus.in_stb  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.in_ack !== 1'b1 && n < 100);
        chk("ack_seen", 32'(n < 100), 32'd1);
        prev_ack   = last_ack;
        last_ack   = cyc;
        bus.in_stb = 1'b0;
        @(negedge clk);
        chk("ack_pulse", 32'(bus.in_ack), 32'd0);
    endtask

    task automatic expect_out(input string tag, input logic [15:0] res, input logic [2:0] err);
        chk({tag, " stb"}, 32'(bus.out_stb), 32'd1);
        chk({tag, " result"}, 32'(bus.out_result), 32'(res));
        chk({tag, " err"}, 32'(bus.out_err), 32'(err));
        bus.out_ack = 1'b1;
        @(negedge clk);
        bus.out_ack = 1'b0;
        chk({tag, " stb_drop"}, 32'(bus.out_stb), 32'd0);
    endtask

    task automatic run(input string s, input logic [15:0] res, input logic [2:0] err);
        for (int i = 0; i < s.len(); i++) send(s[i]);
        expect_out(s, res, err);
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        bus.in_stb  = 1'b0;
        bus.in_char = 8'h00;
        bus.out_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst in_ack", 32'(bus.in_ack), 32'd0);
        chk("rst out_stb", 32'(bus.out_stb), 32'd0);
        chk("rst out_result", 32'(bus.out_result), 32'd0);
        chk("rst out_err", 32'(bus.out_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic arithmetic with back-to-back digit timing
        send("3");
        send("4");
        chk("gap_digit", 32'(last_ack - prev_ack), 32'd2);
        send("+");
        send("=");
        expect_out("34+=", 16'd7, 3'd0);
        run("93-2*=", 16'd12, 3'd0);
        run("25-=", 16'hFFFD, 3'd0);
        run("99*9*=", 16'h02D9, 3'd0);

        // Division: result and the WIDTH-cycle stall before the next sample
        send("0");
        send("7");
        send("-");
        send("2");
        send("/");
        div_ack = last_ack;
        send("=");
        chk("gap_div", 32'(last_ack - div_ack), 32'(WIDTH + 2));
        expect_out("07-2/=", 16'hFFFD, 3'd0);
        run("07-03-/=", 16'd2, 3'd0);
        run("807-/=", 16'hFFFF, 3'd0);

        // Error codes, each followed by a clean expression
        run("50/=", 16'd0, 3'd3);
        run("11+=", 16'd2, 3'd0);
        run("+=", 16'd0, 3'd1);
        run("11+=", 16'd2, 3'd0);
        run("123456789=", 16'd0, 3'd2);
        run("11+=", 16'd2, 3'd0);
        run("12=", 16'd0, 3'd5);
        run("11+=", 16'd2, 3'd0);
        run("1a=", 16'd0, 3'd4);
        run("11+=", 16'd2, 3'd0);

        // Result held while the consumer stalls; a waiting char is taken only after the ack
        send("3");
        send("4");
        send("*");
        send("=");
        bus.in_char = "5";
        bus.in_stb  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold", {11'd0, bus.in_ack, bus.out_stb, bus.out_err, bus.out_result},
                {11'd0, 1'b0, 1'b1, 3'd0, 16'd12});
        end
        bus.out_ack = 1'b1;
        @(negedge clk);
        bus.out_ack = 1'b0;
        chk("hold stb_drop", 32'(bus.out_stb), 32'd0);
        chk("hold no_ack_yet", 32'(bus.in_ack), 32'd0);
        @(negedge clk);
        chk("pending accepted", 32'(bus.in_ack), 32'd1);
        bus.in_stb = 1'b0;
        @(negedge clk);
        send("=");
        expect_out("5=", 16'd5, 3'd0);

        // Reset while a result is being presented
        send("9");
        send("=");
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out out_stb", 32'(bus.out_stb), 32'd0);
        chk("rst_out out_result", 32'(bus.out_result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during a division, then a fresh expression
        send("0");
        send("7");
        send("-");
        send("2");
        send("/");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_div outputs", {15'd0, bus.in_ack, bus.out_stb, bus.out_err, bus.out_result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("22*=", 16'd4, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rpn_eval.md
# rpn_eval

Evaluator stage directly downstream of the infix-to-RPN converter. Consumes its ASCII RPN character stream (single-digit operands, `+ - * /`, `=` terminator) over the same STB/ACK character handshake, evaluates it on an internal operand stack, and presents one signed result per expression, with an error code, on a held-until-acknowledged output port.

## Interface
- `WIDTH`, 16: operand/result width, two's complement.
- `DEPTH`, 8: operand stack entries.
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `IN_STB` in 1: `IN_CHAR` valid.
- `IN_CHAR` in 8: ASCII RPN character.
- `IN_ACK` out 1: one-cycle pulse, character consumed.
- `OUT_STB` out 1: result valid, held until acknowledged.
- `OUT_RESULT` out WIDTH: expression value.
- `OUT_ERR` out 3: 0 none, 1 underflow, 2 overflow, 3 divide-by-zero, 4 bad char, 5 bad terminator.
- `OUT_ACK` in 1: result taken.

## Operation
- States: IDLE, EXEC, DIV, OUT.
- IDLE: samples `IN_CHAR` when `IN_STB`=1 and `IN_ACK`=0. Goes to EXEC, or to OUT for `=`.
- Digit `'0'..'9'`: push zero-extended value.
- Operator: pop b (top) and a (next). Push a op b.
  - `+`, `-`, `*`: low WIDTH bits, wrapping.
  - `/`: signed, truncates toward zero. MIN / -1 = MIN.
- Error detection, first error wins:
  - Operator with fewer than 2 entries: underflow.
  - Push when count = DEPTH: overflow.
  - `/` with b = 0: divide-by-zero.
  - Any other char: bad char.
  - `=` with count ≠ 1: bad terminator.
- Error handling:
  - Errors are sticky. The stack is left unchanged by the erroring char.
  - Later characters are acked and ignored until `=`.
- `=`: `OUT_RESULT` = top if no error, else 0. `OUT_ERR` = code.
- OUT: on `OUT_ACK`=1, the block clears the stack and error and returns to IDLE. No input is accepted while in OUT.

## Timing
- Reset values: `IN_ACK` 0, `OUT_STB` 0, `OUT_RESULT` 0, `OUT_ERR` 0, stack count 0, state IDLE.
- Reset mid-operation, including mid-division: everything returns to reset values at once. The partial result is discarded.
- Char sampled at cycle T: `IN_ACK`=1 at T+1 only.
- Source rules:
  - The source must present the next char or drop `IN_STB` by T+2.
  - A char still on the bus in the `IN_ACK` cycle is not re-sampled.
- Digit, `+`, `-`, `*`: stack updated at end of T+1, back in IDLE. Next sample no earlier than T+2.
- `/`:
  - Operands are latched at T+1.
  - The divider runs cycles T+2..T+WIDTH+1.
  - The quotient is pushed at end of T+WIDTH+1.
  - Next sample no earlier than T+WIDTH+2.
  - Divide-by-zero skips the divider and returns at T+2.
- `=`: `OUT_STB`=1 from T+1, with result and code stable until `OUT_ACK` is sampled high at cycle U.
  - `OUT_STB`=0 at U+1.
  - Next sample no earlier than U+1.
- `OUT_ACK` while `OUT_STB`=0 is ignored.

## Structure
- Package `rpn_pkg` holds:
  - ASCII constants (digits, `+ - * / =`).
  - `OUT_ERR` code constants.
  - State enum.
- Sub-module `rpn_div`:
  - Sequential restoring divider on magnitudes, one quotient bit per cycle over WIDTH cycles.
  - Interface: start/done.
  - Sign fix-up is done in the wrapper.
- Stack: register array plus count, inside `rpn_eval`.

## Test plan
- `"34+="` -> `OUT_RESULT`=7, `OUT_ERR`=0. `IN_ACK` exactly one cycle per char.
- `"93-2*="` -> 12. `"25-="` -> 0xFFFD (-3).
- `"07-2/="` -> 0xFFFD (-3).
  - `/` `IN_ACK` one cycle after sampling.
  - Next char sampled no earlier than WIDTH+1 cycles after the `/` `IN_ACK`.
- Error codes:
  - `"50/="` -> result 0, `OUT_ERR`=3.
  - `"+="` -> 1.
  - `"123456789="` -> 2.
  - `"12="` -> 5.
  - `"1a="` -> 4.
  - After each error, `"11+="` -> 2, `OUT_ERR`=0.
- Hold `OUT_ACK`=0 for 10 cycles with `IN_STB`=1 -> `OUT_STB`, `OUT_RESULT` and `OUT_ERR` stable, `IN_ACK` stays 0. After `OUT_ACK`, the pending char is accepted.
- Assert `RST_N`=0 during a division -> all outputs 0 immediately. After release, `"22*="` -> 4.
